uart_rx: RTL
============

Name: uart_rx

Overview:
- Asynchronous serial receiver and the counterpart of the team's Uart_tx.
- Oversamples RX_IN at a programmable prescale and checks the start bit. Deserializes WIDTH data bits LSB first, then checks optional parity and the stop bit.
- Presents the received word with a one-cycle valid pulse, or a one-cycle error flag.
- Sits between the pad-side serial line and the system register/FIFO path.

Parameters:
- WIDTH, 8, data bits per frame.
- PRESC_W, 6, width of the prescale input. The supported prescale values are 8, 16 and 32.

Ports:
- clk  input  1  system clock; runs at prescale × baud rate.
- rst  input  1  asynchronous, active-high reset.
- RX_IN  input  1  serial line; idles high. Asynchronous to clk.
- prescale  input  PRESC_W  oversampling ratio (8/16/32). Latched at start-of-frame.
- PAR_EN  input  1  1 = frame carries a parity bit. Latched at start-of-frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity. Latched at start-of-frame.
- P_DATA  output  WIDTH  last correctly received word.
- data_valid  output  1  one-cycle pulse when P_DATA is updated.
- par_err  output  1  one-cycle pulse on parity mismatch.
- stp_err  output  1  one-cycle pulse on a stop bit sampled low.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Clock is clk. Reset is asynchronous, active-high, on port rst; it takes effect immediately.
- Reset values:
  - Synchronizer flops = 1.
  - FSM = IDLE.
  - P_DATA = 0; data_valid, par_err, stp_err, busy = 0.
  - edge_cnt = 0, bit_cnt = 0.
- Input path: RX_IN passes through a 2-flop synchronizer. Every timing figure below is relative to the synchronized signal rx_s, which lags RX_IN by 2 cycles.
- Counters:
  - edge_cnt counts 0..P-1 within a bit, where P is the latched prescale.
  - bit_cnt counts data bits 0..WIDTH-1.
  - edge_cnt wraps to 0 at P-1.
- Sampling: the bit value is taken at edge_cnt == P/2 (single sample; see Optional Feature for majority sampling). The bit is decided and acted on at edge_cnt == P-1.
- FSM states:
  - IDLE → START when rx_s == 0. On this transition: edge_cnt = 0, and prescale, PAR_EN, PAR_TYP are latched.
  - START → DATA at edge_cnt == P-1 if the sampled bit is 0. If it is 1 (glitch), go back to IDLE with no output pulse.
  - DATA: each sampled bit is shifted into a shift register LSB first. At edge_cnt == P-1 with bit_cnt == WIDTH-1, go to PARITY if PAR_EN, else to STOP.
  - PARITY: at edge_cnt == P-1, compare the sampled bit against the expected parity. Expected = XOR(data) for even; its inverse for odd. On mismatch: par_err = 1 for one cycle, then IDLE with no data_valid. On match: STOP.
  - STOP: at edge_cnt == P-1, go to IDLE.
    - Sampled 1: P_DATA ← shift register, data_valid = 1 for one cycle.
    - Sampled 0: stp_err = 1 for one cycle; P_DATA is unchanged.
- Latency: data_valid rises 2 + (1 + WIDTH + PAR_EN + 1)·P cycles after the RX_IN falling edge, ±1 cycle.
- Back-to-back frames: the FSM is in IDLE one cycle after the stop decision. A start bit already low at that point is detected on the next cycle (≤1 cycle slip; tolerated).
- busy is high from the IDLE→START transition until the cycle IDLE is re-entered.
- Changes to prescale, PAR_EN or PAR_TYP mid-frame have no effect until the next frame.
- Reset mid-frame: the frame is abandoned with no pulses, and P_DATA returns to 0.
- data_valid, par_err and stp_err are mutually exclusive and never asserted in the same cycle.
- A prescale value outside {8, 16, 32} gives undefined results; no checking is performed.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Three samples are taken at edge_cnt == P/2-1, P/2 and P/2+1. The bit value is their majority (2 of 3).
  - This applies to the start, data, parity and stop bits.
  - A single-sample glitch inside a bit is rejected.
- Undefined: single sample at edge_cnt == P/2. The extra sample registers and voting logic are not built.
- Timing of the decision point (edge_cnt == P-1) is identical in both builds.

Test Plan:
- Basic frame: P=8, PAR_EN=0, send 0xA5 → data_valid pulses once, P_DATA = 0xA5, and the pulse comes ~82 cycles after the start edge. busy is high throughout.
- Even parity: P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → P_DATA = 0x3C. Resend with parity 1 → par_err pulse, no data_valid, P_DATA stays 0x3C.
- Odd parity and stop error: P=32, PAR_TYP=1, send 0x01 with parity 0 → valid. Send 0xFF with correct parity 1 but stop = 0 → stp_err pulse, P_DATA unchanged.
- False start: RX_IN low for 2 cycles at P=16 → FSM returns to IDLE at the end of START with no pulses. A following valid frame with 0x55 is received correctly.
- Back-to-back and reset: three consecutive P=8 frames 0x11/0x22/0x33 with no idle gap → three data_valid pulses in order. Assert rst mid-data of a fourth frame → all outputs 0 immediately; the next frame 0x44 is received cleanly.
- UART_RX_MAJORITY_EN: P=16, inject a 1-cycle inverted spike at edge_cnt == 8 of data bit 3 of 0x00 → with the macro, P_DATA = 0x00; without it, P_DATA = 0x08.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle between the serial pad side and the uart_rx receiver.
// master = line driver / result consumer, slave = the receiver itself.
interface uart_rx_if #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic [PRESC_W-1:0] prescale;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic [WIDTH-1:0]   P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;
  logic               busy;

  // No back-pressure: data_valid, par_err and stp_err are single-cycle pulses,
  // mutually exclusive; P_DATA changes only in the cycle data_valid is high
  // and holds until the next good frame. The consumer must take it on that cycle.
  modport master (
    output RX_IN, prescale, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, prescale, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start check, LSB-first data, optional parity, stop check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  uart_rx_if.slave   rx_if,
  output logic [2:0] dbg_state_o
);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRESC_W-1:0] ONE_E    = PRESC_W'(1);
  localparam logic [BIT_W-1:0]   ONE_B    = BIT_W'(1);
  localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, rx_s_q;
  logic [PRESC_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d;
  logic               par_typ_q, par_typ_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   pdata_q, pdata_d;
  logic               valid_q, valid_d;
  logic               perr_q, perr_d;
  logic               serr_q, serr_d;
  logic [PRESC_W-1:0] half;
  logic               last_edge;
  logic               bit_val;
  logic               exp_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_if.RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  assign half      = presc_q >> 1;
  assign last_edge = (edge_q == presc_q - ONE_E);

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] vote_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= 3'b111;
    end else if (state_q != IDLE) begin
      if (edge_q == half - ONE_E) vote_q[0] <= rx_s_q;
      if (edge_q == half)         vote_q[1] <= rx_s_q;
      if (edge_q == half + ONE_E) vote_q[2] <= rx_s_q;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                   (vote_q[1] & vote_q[2]);
`else
  logic samp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_q <= 1'b1;
    end else if (state_q != IDLE && edge_q == half) begin
      samp_q <= rx_s_q;
    end
  end

  assign bit_val = samp_q;
`endif

  // Parity is judged against the fully assembled word.
  assign exp_par = (^shift_q) ^ par_typ_q;

  always_comb begin
    state_d   = state_q;
    edge_d    = last_edge ? '0 : edge_q + ONE_E;
    bit_d     = bit_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        if (!rx_s_q) begin
          state_d   = START;
          presc_d   = rx_if.prescale;
          par_en_d  = rx_if.PAR_EN;
          par_typ_d = rx_if.PAR_TYP;
        end
      end
      START: begin
        if (last_edge) begin
          bit_d   = '0;
          state_d = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_edge) begin
          shift_d = {bit_val, shift_q[WIDTH-1:1]};
          bit_d   = bit_q + ONE_B;
          if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) begin
          if (bit_val != exp_par) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (last_edge) begin
          state_d = IDLE;
          if (bit_val) begin
            pdata_d = shift_q;
            valid_d = 1'b1;
          end else begin
            serr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      shift_q   <= '0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign rx_if.P_DATA     = pdata_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.par_err    = perr_q;
  assign rx_if.stp_err    = serr_q;
  assign rx_if.busy       = (state_q != IDLE);
  assign dbg_state_o      = state_q;
endmodule
